clock_div_prog: RTL and testbench

//   Synthesizable, run-time programmable clock divider. Replaces fixed-delay divider models.

---
 rtl/clock_div_prog_if.sv | 29 ++
 rtl/clock_div_prog.sv | 97 +++++++++
 tb/tb_clock_div_prog.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/clock_div_prog_if.sv
`default_nettype none
// ============================================================================
// Module   : clock_div_prog_if
// Brief    : Control/status bundle of the programmable clock divider.
// Revision : 1.0 - initial release
// ============================================================================
interface clock_div_prog_if #(
    parameter int W = 8
);
    logic         enable;
    logic [W-1:0] div_in;
    logic         div_load;
    logic         clk_out;
    logic         tick;
    logic [W-1:0] div_cur;
    logic         pending;
    logic         err;

    modport master (
        output enable, div_in, div_load,
        input  clk_out, tick, div_cur, pending, err
    );

    modport slave (
        input  enable, div_in, div_load,
        output clk_out, tick, div_cur, pending, err
    );
endinterface
`default_nettype wire

// File: rtl/clock_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : clock_div_prog
// Brief    : Run-time programmable divider producing a square wave and a tick
//            enable; new ratios are applied only at period boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module clock_div_prog #(
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    clock_div_prog_if.slave    bus
);
    localparam logic [W-1:0] c_DEFAULT_DIV = W'(DEFAULT_DIV);
    localparam logic [W-1:0] c_ONE         = W'(1);
    localparam logic [W-1:0] c_TWO         = W'(2);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] div_cur_q, div_cur_d;
    logic [W-1:0] pend_val_q, pend_val_d;
    logic         pending_q, pending_d;
    logic         clk_out_q, clk_out_d;
    logic         tick_q, tick_d;
    logic         err_q, err_d;

    logic         w_last;
    logic         w_boundary;
    logic [W-1:0] w_n_eff;
    logic [W-1:0] w_half;
    logic [W-1:0] w_cnt_nxt;

    assign w_last     = (cnt_q == (div_cur_q - c_ONE));
    assign w_boundary = w_last && pending_q;
    assign w_cnt_nxt  = w_last ? '0 : (cnt_q + c_ONE);
    // Waveform on a boundary edge is already shaped by the incoming ratio.
    assign w_n_eff    = w_boundary ? pend_val_q : div_cur_q;
    assign w_half     = w_n_eff - (w_n_eff >> 1);

    always_comb begin
        cnt_d      = cnt_q;
        div_cur_d  = div_cur_q;
        pend_val_d = pend_val_q;
        pending_d  = pending_q;
        clk_out_d  = clk_out_q;
        tick_d     = 1'b0;
        err_d      = 1'b0;

        if (bus.enable) begin
            cnt_d     = w_cnt_nxt;
            clk_out_d = (w_cnt_nxt < w_half);
            tick_d    = (w_cnt_nxt == '0);
            if (w_boundary) begin
                div_cur_d = pend_val_q;
                pending_d = 1'b0;
            end
        end

        // A load on a boundary edge queues behind the value just applied.
        if (bus.div_load) begin
            if (bus.div_in >= c_TWO) begin
                pend_val_d = bus.div_in;
                pending_d  = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= c_DEFAULT_DIV - c_ONE;
            div_cur_q  <= c_DEFAULT_DIV;
            pend_val_q <= '0;
            pending_q  <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            pend_val_q <= pend_val_d;
            pending_q  <= pending_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end

    assign bus.clk_out = clk_out_q;
    assign bus.tick    = tick_q;
    assign bus.div_cur = div_cur_q;
    assign bus.pending = pending_q;
    assign bus.err     = err_q;
endmodule
`default_nettype wire

// File: tb/tb_clock_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_div_prog
// Brief    : Self-checking bench for clock_div_prog (vector table, directed
//            corner sequences, randomized run against a period-level model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_div_prog;
    localparam int W   = 8;
    localparam int DEF = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    clock_div_prog_if #(.W(W)) ifc ();

    clock_div_prog #(.W(W), .DEFAULT_DIV(DEF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position within the current period and period length.
    int m_pos, m_n, m_pv;
    bit m_pend, m_clk, m_tick, m_err;

    typedef struct {
        bit        rst;
        bit        en;
        bit        ld;
        bit [7:0]  din;
        bit        e_clk;
        bit        e_tick;
        bit [7:0]  e_cur;
        bit        e_pend;
        bit        e_err;
    } vec_t;

    vec_t vecs[16];

    task automatic model_edge(input bit r, input bit e, input bit l, input int d);
        if (r) begin
            m_n = DEF; m_pos = DEF - 1; m_pv = 0;
            m_pend = 0; m_clk = 0; m_tick = 0; m_err = 0;
        end else begin
            m_err = l && (d < 2);
            if (e) begin
                if (m_pos == m_n - 1) begin
                    m_pos = 0;
                    if (m_pend) begin
                        m_n = m_pv;
                        m_pend = 0;
                    end
                end else begin
                    m_pos = m_pos + 1;
                end
                m_clk  = (m_pos < (m_n + 1) / 2);
                m_tick = (m_pos == 0);
            end else begin
                m_tick = 0;
            end
            if (l && d >= 2) begin
                m_pv = d;
                m_pend = 1;
            end
        end
    endtask

    task automatic check_model();
        n_checks++;
        if (ifc.clk_out !== m_clk || ifc.tick !== m_tick || ifc.div_cur !== W'(m_n) ||
            ifc.pending !== m_pend || ifc.err !== m_err) begin
            n_fail++;
            $display("FAIL model t=%0t: got clk_out=%b tick=%b div_cur=%0d pending=%b err=%b, required %b %b %0d %b %b",
                     $time, ifc.clk_out, ifc.tick, ifc.div_cur, ifc.pending, ifc.err,
                     m_clk, m_tick, m_n, m_pend, m_err);
        end
    endtask

    task automatic expect_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Apply inputs, advance one edge, update model, sample 1 time unit later.
    task automatic step(input bit r, input bit e, input bit l, input int d);
        reset        = r;
        ifc.enable   = e;
        ifc.div_load = l;
        ifc.div_in   = W'(d);
        @(posedge clk);
        model_edge(r, e, l, d);
        #1;
        check_model();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int hi, lo, ticks, guard;
        reset = 1'b1; ifc.enable = 1'b0; ifc.div_load = 1'b0; ifc.div_in = '0;
        m_n = DEF; m_pos = DEF - 1; m_pv = 0; m_pend = 0; m_clk = 0; m_tick = 0; m_err = 0;

        // ---------------- table-driven vectors ----------------
        vecs[0]  = '{1, 1, 0, 0, 0, 0, 4, 0, 0};
        vecs[1]  = '{0, 1, 0, 0, 1, 1, 4, 0, 0};
        vecs[2]  = '{0, 1, 0, 0, 1, 0, 4, 0, 0};
        vecs[3]  = '{0, 1, 1, 0, 0, 0, 4, 0, 1};
        vecs[4]  = '{0, 1, 1, 1, 0, 0, 4, 0, 1};
        vecs[5]  = '{0, 1, 0, 0, 1, 1, 4, 0, 0};
        vecs[6]  = '{0, 1, 1, 3, 1, 0, 4, 1, 0};
        vecs[7]  = '{0, 1, 0, 0, 0, 0, 4, 1, 0};
        vecs[8]  = '{0, 1, 0, 0, 0, 0, 4, 1, 0};
        vecs[9]  = '{0, 1, 0, 0, 1, 1, 3, 0, 0};
        vecs[10] = '{0, 1, 0, 0, 1, 0, 3, 0, 0};
        vecs[11] = '{0, 1, 0, 0, 0, 0, 3, 0, 0};
        vecs[12] = '{0, 1, 0, 0, 1, 1, 3, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 1, 0, 3, 0, 0};
        vecs[14] = '{0, 1, 0, 0, 1, 0, 3, 0, 0};
        vecs[15] = '{1, 1, 1, 9, 0, 0, 4, 0, 0};

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].ld, int'(vecs[i].din));
            n_checks++;
            if (ifc.clk_out !== vecs[i].e_clk || ifc.tick !== vecs[i].e_tick ||
                ifc.div_cur !== vecs[i].e_cur || ifc.pending !== vecs[i].e_pend ||
                ifc.err !== vecs[i].e_err) begin
                n_fail++;
                $display("FAIL vec%0d: got clk_out=%b tick=%b div_cur=%0d pending=%b err=%b, required %b %b %0d %b %b",
                         i, ifc.clk_out, ifc.tick, ifc.div_cur, ifc.pending, ifc.err,
                         vecs[i].e_clk, vecs[i].e_tick, vecs[i].e_cur, vecs[i].e_pend, vecs[i].e_err);
            end
        end

        // ---------------- 24 ticks in 96 cycles at N=4 ----------------
        step(1, 0, 0, 0);
        ticks = 0;
        for (int i = 0; i < 96; i++) begin
            step(0, 1, 0, 0);
            if (ifc.tick) ticks++;
        end
        expect_eq("ticks_96", ticks, 24);

        // ---------------- freeze at cnt=2 ----------------
        step(1, 0, 0, 0);
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0);
            expect_eq("frozen_clk_out", int'(ifc.clk_out), 0);
            expect_eq("frozen_tick", int'(ifc.tick), 0);
        end
        step(0, 1, 0, 0);
        expect_eq("resume_cnt3_tick", int'(ifc.tick), 0);
        step(0, 1, 0, 0);
        expect_eq("resume_wrap_tick", int'(ifc.tick), 1);
        expect_eq("resume_wrap_clk", int'(ifc.clk_out), 1);

        // ---------------- reset before a queued boundary ----------------
        step(1, 0, 0, 0);
        step(0, 1, 0, 0); step(0, 1, 0, 0);
        step(0, 1, 1, 6);
        expect_eq("pend_before_reset", int'(ifc.pending), 1);
        step(1, 1, 0, 0);
        expect_eq("rst_div_cur", int'(ifc.div_cur), 4);
        expect_eq("rst_pending", int'(ifc.pending), 0);
        expect_eq("rst_clk_out", int'(ifc.clk_out), 0);
        step(0, 1, 0, 0);
        expect_eq("restart_tick", int'(ifc.tick), 1);

        // ---------------- N=255 duty cycle, load 2 on boundary edge ----------------
        step(0, 1, 1, 255);
        guard = 0;
        while (ifc.div_cur !== 8'd255 && guard < 20) begin
            step(0, 1, 0, 0);
            guard++;
        end
        expect_eq("reach_255", int'(ifc.div_cur), 255);
        hi = ifc.clk_out ? 1 : 0;
        lo = ifc.clk_out ? 0 : 1;
        for (int i = 1; i < 255; i++) begin
            step(0, 1, 0, 0);
            if (ifc.clk_out) hi++; else lo++;
        end
        expect_eq("n255_high", hi, 128);
        expect_eq("n255_low", lo, 127);
        step(0, 1, 1, 2);
        expect_eq("bnd_load_div_cur", int'(ifc.div_cur), 255);
        expect_eq("bnd_load_pending", int'(ifc.pending), 1);
        ticks = 0;
        for (int i = 1; i < 255; i++) begin
            step(0, 1, 0, 0);
            if (ifc.tick) ticks++;
        end
        expect_eq("n255_repeat_no_tick", ticks, 0);
        step(0, 1, 0, 0);
        expect_eq("n2_div_cur", int'(ifc.div_cur), 2);
        expect_eq("n2_clk_hi", int'(ifc.clk_out), 1);
        step(0, 1, 0, 0);
        expect_eq("n2_clk_lo", int'(ifc.clk_out), 0);
        step(0, 1, 0, 0);
        expect_eq("n2_tick", int'(ifc.tick), 1);

        // ---------------- randomized run vs model ----------------
        step(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            bit r, e, l;
            int d;
            r = ($urandom_range(0, 299) == 0);
            e = ($urandom_range(0, 99) < 85);
            l = ($urandom_range(0, 13) == 0);
            d = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 20));
            step(r, e, l, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
